// File: rtl/id_operand_unit.sv
// id_operand_unit
//   ID-stage operand supplier for the 5-stage MIPS core. It holds the
//   architectural register file and resolves the rs/rt operands. Forwarding
//   priority is EX > IO > WB write-through > storage. It raises a load-use
//   interlock stall when a needed result is not yet available, and it counts
//   stalled cycles in a saturating counter.
//
// Ports
//   clock, reset            core clock; synchronous active-high reset
//   id_valid                ID holds a valid instruction
//   rs_used, rt_used        instruction reads rs / rt
//   rs_address, rt_address  source register indices
//   rs_data, rt_data        resolved operands (don't-care while stalled)
//   operand_stall           ID must not go
//   ex_bp_*                 EX back-pass: destination (0 = none), data, ready
//   io_bp_*                 IO back-pass: destination (0 = none), data, ready
//   wb_write_*              WB register-file write port
//   stall_count             saturating count of stalled cycles
module id_operand_unit #(
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned ADDRESS_WIDTH       = 5,
  parameter int unsigned STALL_COUNTER_WIDTH = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           id_valid,
  input  logic                           rs_used,
  input  logic                           rt_used,
  input  logic [ADDRESS_WIDTH-1:0]       rs_address,
  input  logic [ADDRESS_WIDTH-1:0]       rt_address,
  output logic [DATA_WIDTH-1:0]          rs_data,
  output logic [DATA_WIDTH-1:0]          rt_data,
  output logic                           operand_stall,
  input  logic [ADDRESS_WIDTH-1:0]       ex_bp_write_register,
  input  logic [DATA_WIDTH-1:0]          ex_bp_write_data,
  input  logic                           ex_bp_data_ready,
  input  logic [ADDRESS_WIDTH-1:0]       io_bp_write_register,
  input  logic [DATA_WIDTH-1:0]          io_bp_write_data,
  input  logic                           io_bp_data_ready,
  input  logic                           wb_write_enabled,
  input  logic [ADDRESS_WIDTH-1:0]       wb_write_address,
  input  logic [DATA_WIDTH-1:0]          wb_write_data,
  output logic [STALL_COUNTER_WIDTH-1:0] stall_count
);

  localparam int unsigned REGISTER_COUNT = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] registers [REGISTER_COUNT];
  logic                  rs_hazard;
  logic                  rt_hazard;

  // Register file. Entry 0 is held at zero and is never written.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < REGISTER_COUNT; i++) begin
        registers[i] <= '0;
      end
    end else if (wb_write_enabled && (wb_write_address != '0)) begin
      registers[wb_write_address] <= wb_write_data;
    end
  end

  // Back-pass address 0 means "no write", so it never matches. Address 0 is
  // handled before the matches.
  function automatic logic [DATA_WIDTH-1:0] resolve(input logic [ADDRESS_WIDTH-1:0] address);
    if (address == '0)
      return '0;
    else if (address == ex_bp_write_register)
      return ex_bp_write_data;
    else if (address == io_bp_write_register)
      return io_bp_write_data;
    else if (wb_write_enabled && (address == wb_write_address))
      return wb_write_data;
    else
      return registers[address];
  endfunction

  // The youngest matching producer decides. A ready EX match hides any
  // not-ready IO match on the same register.
  function automatic logic hazard(input logic used, input logic [ADDRESS_WIDTH-1:0] address);
    logic result;
    result = 1'b0;
    if (id_valid && used && (address != '0)) begin
      if (address == ex_bp_write_register)
        result = !ex_bp_data_ready;
      else if (address == io_bp_write_register)
        result = !io_bp_data_ready;
    end
    return result;
  endfunction

  always_comb begin
    rs_data       = resolve(rs_address);
    rt_data       = resolve(rt_address);
    rs_hazard     = hazard(rs_used, rs_address);
    rt_hazard     = hazard(rt_used, rt_address);
    operand_stall = rs_hazard | rt_hazard;
  end

  always_ff @(posedge clock) begin
    if (reset)
      stall_count <= '0;
    else if (operand_stall && (stall_count != '1))
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: doc/id_operand_unit.md
Name: id_operand_unit

Overview:
- ID-stage operand supplier for the 5-stage MIPS core; the receiving end of the WB-stage register-file write bus and of the EX/IO/WB back-pass buses.
- Holds the 32x32 architectural register file and resolves rs/rt operands with forwarding priority EX > IO > WB > storage.
- Raises a load-use interlock stall when a needed result is not yet available.
- Counts stall cycles for performance debug.

Parameters:
DATA_WIDTH, 32, register and operand width
ADDRESS_WIDTH, 5, register index width (2**ADDRESS_WIDTH registers)
STALL_COUNTER_WIDTH, 32, width of saturating stall-cycle counter

Ports:
clock  input  1  core clock
reset  input  1  synchronous, active-high
id_valid  input  1  ID holds a valid instruction
rs_used  input  1  instruction reads rs
rt_used  input  1  instruction reads rt
rs_address  input  5  rs index
rt_address  input  5  rt index
rs_data  output  32  resolved rs operand
rt_data  output  32  resolved rt operand
operand_stall  output  1  ID must not go (ready_go low)
ex_bp_write_register  input  5  EX destination; 0 = no write
ex_bp_write_data  input  32  EX result
ex_bp_data_ready  input  1  EX result valid (0 for loads in EX)
io_bp_write_register  input  5  IO destination; 0 = no write
io_bp_write_data  input  32  IO result
io_bp_data_ready  input  1  IO result valid (0 while load data outstanding)
wb_write_enabled  input  1  WB register write strobe (already qualified by wb_valid)
wb_write_address  input  5  WB destination
wb_write_data  input  32  WB final result
stall_count  output  32  saturating count of cycles with operand_stall=1

Behaviour:
- Reset (clock, reset: synchronous, active-high): all registers <= 0, stall_count <= 0. A WB write in the reset cycle is dropped.
- Storage write: at posedge when wb_write_enabled=1 and wb_write_address!=0, reg[wb_write_address] <= wb_write_data. Register 0 is never written and always reads 0.
- Operand resolution is combinational, zero latency, and identical for rs and rt. For address A:
  - A=0 -> 0.
  - A==ex_bp_write_register -> ex_bp_write_data.
  - else A==io_bp_write_register -> io_bp_write_data.
  - else wb_write_enabled and A==wb_write_address -> wb_write_data (write-through).
  - else reg[A].
- A back-pass address of 0 never matches, so producers signal "no write" by driving 0.
- Hazard for source S = id_valid & S_used & (S_address!=0) & any of:
  - S_address==ex_bp_write_register & !ex_bp_data_ready
  - S_address==io_bp_write_register & !io_bp_data_ready (only when EX does not match)
- Rule: the youngest match decides. If EX matches with data ready, an IO not-ready match is ignored.
- operand_stall = hazard(rs) | hazard(rt). It is 0 whenever id_valid=0 and is 0 out of reset.
- Data on rs_data/rt_data during a stall is don't-care.
- stall_count: +1 each posedge with operand_stall=1 and reset=0; saturates at all-ones (no wrap).
- Simultaneous EX, IO and WB matches on the same register: EX wins. Simultaneous WB write and read of the same register: new value is returned in the same cycle.
- Reset mid-stall: stall_count clears; operand_stall follows the inputs combinationally.

Test Plan:
- Reset, then read rs=5, rt=0 with no back-pass activity -> rs_data=0, rt_data=0, operand_stall=0, stall_count=0.
- WB writes r7=0x1234_5678 while rs_address=7 in the same cycle -> rs_data=0x1234_5678 that cycle (write-through). Next cycle with WB idle -> still 0x1234_5678 from storage. WB write to r0=0xFFFF_FFFF -> r0 reads 0.
- reg r3=0x11; IO bp r3 data 0x22 ready; EX bp r3 data 0x33 ready; rs=r3 -> 0x33. Drop EX (addr 0) -> 0x22. Drop IO -> 0x11.
- Load-use: id_valid=1, rs_used=1, rs=9, EX bp r9 not ready for 1 cycle, then IO bp r9 not ready for 2 cycles, then IO ready with 0xABCD -> operand_stall high 3 cycles, then rs_data=0xABCD with stall low; stall_count=3.
- Same hazard with rs_used=0 or id_valid=0 -> operand_stall=0 and stall_count unchanged. EX r9 ready while IO r9 not ready -> no stall, EX data used.
- Force stall_count to all-ones minus 1 (or narrow STALL_COUNTER_WIDTH=2), stall 3 cycles -> holds 3 (saturates). Assert reset during a stall -> stall_count=0 next cycle and all registers read 0.
